// File: rtl/spi_flash_master_pkg.sv
// Shared definitions for the SPI flash master: FSM state encoding and the
// IO addresses used by the top-level decode and io_din mux.
package spi_flash_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [15:0] adr_spi_data = 16'h0010;
  localparam logic [15:0] adr_spi_cs   = 16'h0011;

  localparam int unsigned BITS_PER_XFER = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI master: terminal-count pulse, a sample-point
// pulse at a fixed count, and a synchronous clear used on every state change.
module spi_clk_div #(
  parameter int HALF_PERIOD = 2,
  parameter int SAMPLE_AT   = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc,
  output logic o_sample
);

  localparam logic [7:0] TC_VAL  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] SMP_VAL = 8'(SAMPLE_AT);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 8'd1;
  end

  assign o_tc     = i_en && (r_cnt == TC_VAL);
  assign o_sample = i_en && (r_cnt == SMP_VAL);

endmodule

// File: rtl/spi_flash_master.sv
// Byte-wide SPI mode-0 master for the configuration flash, MSB first.
// Build option SPI_MISO_SYNC_EN: 2-flop MISO synchroniser, sampled 2 cycles into SCK high.
//
// state   | meaning
// IDLE    | no transfer, SCK low, waiting for tx_wr
// LOW     | SCK low for HALF_PERIOD cycles, MOSI holds current bit
// HIGH    | SCK high for HALF_PERIOD cycles, then next bit or finish
module spi_flash_master
  import spi_flash_master_pkg::*;
#(
  parameter int   HALF_PERIOD = 2,
  parameter logic CS_IDLE     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_wr,
  input  logic [7:0] i_tx_data,
  input  logic       i_cs_wr,
  input  logic       i_cs_data,
  output logic [7:0] o_rx_data,
  output logic       o_busy,
  output logic       o_spi_sck,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_ssb
);

  if (HALF_PERIOD < 1 || HALF_PERIOD > 255) begin : g_hp_range
    $error("spi_flash_master: HALF_PERIOD must be in 1..255");
  end

`ifdef SPI_MISO_SYNC_EN
  if (HALF_PERIOD < 3) begin : g_hp_sync
    $error("spi_flash_master: HALF_PERIOD must be >= 3 with SPI_MISO_SYNC_EN");
  end
  // Synchronised MISO lags 2 cycles, so sampling at count 1 of HIGH sees the rising-edge value.
  localparam int     SAMPLE_AT = 1;
  localparam state_t SAMPLE_ST = ST_HIGH;
`else
  localparam int     SAMPLE_AT = HALF_PERIOD - 1;
  localparam state_t SAMPLE_ST = ST_LOW;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic [7:0] r_rx_data;
  logic       r_busy;
  logic       r_sck;
  logic       r_mosi;
  logic       r_ssb;
  logic       w_miso;

  logic w_tc;
  logic w_smp;
  logic w_div_en;
  logic w_div_clr;
  logic w_start;
  logic w_rise;
  logic w_fall;
  logic w_last;
  logic w_sample;

`ifdef SPI_MISO_SYNC_EN
  logic r_miso_s1;
  logic r_miso_s2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= i_spi_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  assign w_miso = r_miso_s2;
`else
  assign w_miso = i_spi_miso;
`endif

  spi_clk_div #(
    .HALF_PERIOD (HALF_PERIOD),
    .SAMPLE_AT   (SAMPLE_AT)
  ) u_clk_div (
    .i_clk    (i_clk),
    .i_rst    (i_reset),
    .i_en     (w_div_en),
    .i_clr    (w_div_clr),
    .o_tc     (w_tc),
    .o_sample (w_smp)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_tx_wr) w_state_nxt = ST_LOW;
      ST_LOW:  if (w_tc)    w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_tc)    w_state_nxt = (r_bit == 3'd7) ? ST_IDLE : ST_LOW;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_rise    = 1'b0;
    w_fall    = 1'b0;
    w_last    = 1'b0;
    w_sample  = 1'b0;
    w_div_en  = 1'b0;
    case (r_state)
      ST_IDLE: w_start = i_tx_wr;
      ST_LOW: begin
        w_div_en = 1'b1;
        w_rise   = w_tc;
      end
      ST_HIGH: begin
        w_div_en = 1'b1;
        w_fall   = w_tc;
        w_last   = w_tc && (r_bit == 3'd7);
      end
      default: ;
    endcase
    w_sample  = (r_state == SAMPLE_ST) && w_smp;
    w_div_clr = w_start || w_rise || w_fall;
  end

  // MISO enters the LSB as the shift happens; MOSI is re-loaded from bit 7 on the falling edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit     <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_ssb     <= CS_IDLE;
    end else begin
      if (i_cs_wr)
        r_ssb <= i_cs_data;
      if (w_start) begin
        r_shift <= i_tx_data;
        r_mosi  <= i_tx_data[7];
        r_busy  <= 1'b1;
        r_bit   <= '0;
      end
      if (w_rise)
        r_sck <= 1'b1;
      if (w_sample)
        r_shift <= {r_shift[6:0], w_miso};
      if (w_fall) begin
        r_sck <= 1'b0;
        if (w_last) begin
          r_rx_data <= r_shift;
          r_busy    <= 1'b0;
          r_mosi    <= 1'b0;
          r_bit     <= '0;
        end else begin
          r_mosi <= r_shift[7];
          r_bit  <= r_bit + 3'd1;
        end
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_busy     = r_busy;
  assign o_spi_sck  = r_sck;
  assign o_spi_mosi = r_mosi;
  assign o_spi_ssb  = r_ssb;

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench for spi_flash_master (HALF_PERIOD=2): table of transfers plus
// hand-written sequences for busy re-strobe, chip select and mid-transfer reset.
module tb_spi_flash_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       cs_wr = 1'b0;
  logic       cs_data = 1'b1;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic       spi_ssb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_flash_master #(.HALF_PERIOD(2), .CS_IDLE(1'b1)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_tx_wr    (tx_wr),
    .i_tx_data  (tx_data),
    .i_cs_wr    (cs_wr),
    .i_cs_data  (cs_data),
    .o_rx_data  (rx_data),
    .o_busy     (busy),
    .o_spi_sck  (spi_sck),
    .o_spi_mosi (spi_mosi),
    .i_spi_miso (spi_miso),
    .o_spi_ssb  (spi_ssb)
  );

  typedef struct {
    string      name;
    logic [7:0] tx;
    logic [7:0] miso_b;
    bit         loopback;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  // Runs one transfer from an idle negedge. inj >= 0 re-strobes tx_wr=FF while busy;
  // cs_lo drops chip select in the same cycle as the start strobe.
  task automatic run_vec(input string nm, input logic [7:0] tx, input logic [7:0] miso_b,
                         input bit loopback, input int inj, input bit cs_lo,
                         input logic [7:0] exp_rx);
    int         busy_cyc = 0;
    int         rises = 0;
    int         hi = 0;
    bit         done = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] mosi_seen = 8'h00;
    @(negedge clk);
    tx_wr   = 1'b1;
    tx_data = tx;
    if (cs_lo) begin
      cs_wr   = 1'b1;
      cs_data = 1'b0;
    end
    spi_miso = loopback ? tx[7] : miso_b[7];
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      cs_wr = 1'b0;
      if (c == 0 && cs_lo) chk({nm, "_ssb_low"}, int'(spi_ssb), 0);
      if (!busy) begin
        done = 1;
        break;
      end
      busy_cyc++;
      if (spi_sck) hi++;
      if (spi_sck && !prev_sck) begin
        mosi_seen = {mosi_seen[6:0], spi_mosi};
        rises++;
      end
      prev_sck = spi_sck;
      if (!spi_sck)
        spi_miso = loopback ? spi_mosi : ((rises < 8) ? miso_b[7 - rises] : 1'b0);
      if (inj >= 0 && busy_cyc == inj) begin
        tx_wr   = 1'b1;
        tx_data = 8'hFF;
      end
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_busy_cycles"}, busy_cyc, 32);
    chk({nm, "_sck_rises"}, rises, 8);
    chk({nm, "_sck_high_cycles"}, hi, 16);
    chk({nm, "_mosi_bits"}, int'(mosi_seen), int'(tx));
    chk({nm, "_rx_data"}, int'(rx_data), int'(exp_rx));
    chk({nm, "_mosi_idle"}, int'(spi_mosi), 0);
    if (cs_lo) chk({nm, "_ssb_held"}, int'(spi_ssb), 0);
    if (inj >= 0) begin
      repeat (6) @(negedge clk);
      chk({nm, "_no_restart"}, int'(busy), 0);
      chk({nm, "_rx_kept"}, int'(rx_data), int'(exp_rx));
    end
  endtask

  initial begin
    vecs[0] = '{"loop_a5",  8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{"flash_9f", 8'h9F, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{"ones_in",  8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{"zeros_in", 8'hFF, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{"edge_81",  8'h81, 8'h7E, 1'b0, 8'h7E};
    vecs[5] = '{"loop_5a",  8'h5A, 8'h00, 1'b1, 8'h5A};

    repeat (3) @(negedge clk);
    chk("rst_sck", int'(spi_sck), 0);
    chk("rst_mosi", int'(spi_mosi), 0);
    chk("rst_ssb", int'(spi_ssb), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rx", int'(rx_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i].name, vecs[i].tx, vecs[i].miso_b, vecs[i].loopback, -1, 1'b0,
              vecs[i].exp_rx);

    // tx_wr=FF strobed mid-transfer must neither restart nor corrupt an all-zero byte
    run_vec("busy_restrobe", 8'h00, 8'hC3, 1'b0, 4, 1'b0, 8'hC3);

    run_vec("cs_xfer", 8'hC3, 8'h96, 1'b0, -1, 1'b1, 8'h96);
    @(negedge clk);
    cs_wr   = 1'b1;
    cs_data = 1'b1;
    @(negedge clk);
    cs_wr = 1'b0;
    chk("cs_release_ssb", int'(spi_ssb), 1);
    chk("cs_release_sck", int'(spi_sck), 0);

    // Mid-transfer reset with chip select asserted and a non-zero rx_data held
    cs_wr   = 1'b1;
    cs_data = 1'b0;
    @(negedge clk);
    cs_wr = 1'b0;
    chk("pre_rst_ssb", int'(spi_ssb), 0);
    tx_wr   = 1'b1;
    tx_data = 8'hA5;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_sck_high", int'(spi_sck), 1);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sck", int'(spi_sck), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ssb", int'(spi_ssb), 1);
    chk("mid_rst_rx", int'(rx_data), 0);
    chk("mid_rst_mosi", int'(spi_mosi), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec("post_rst_55", 8'h55, 8'h00, 1'b1, -1, 1'b0, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
